uart_tx_fifo_reader: RTL and testbench
======================================

Name: uart_tx_fifo_reader

Overview:
Read-side consumer of the UART TX FIFO. It pops bytes from the FIFO read port (empty/inc/data) and serializes each one as a UART frame: one start bit, D_SIZE data bits LSB first, an optional parity bit, and one stop bit. It sits in the read-clock domain, between the FIFO and the serial line.

Parameters:
D_SIZE, 8, data bits per frame; equals the FIFO word width.
PRESC_W, 8, width of the runtime clocks-per-bit input.

Ports:
i_clk  in  1  read-domain clock
i_rstn  in  1  reset, synchronous, active-low
i_fifo_empty  in  1  FIFO empty flag; when low, i_fifo_data is valid (show-ahead)
i_fifo_data  in  D_SIZE  FIFO read data at the current read address
o_fifo_inc  out  1  read-pointer increment, one-cycle pulse per popped word
i_par_en  in  1  1 = append a parity bit
i_par_typ  in  1  0 = even parity, 1 = odd parity
i_prescale  in  PRESC_W  clock cycles per serial bit; 0 is treated as 1
o_tx  out  1  serial line, idle high, registered
o_busy  out  1  high while a frame is in progress

Behaviour:
- Reset (i_rstn low at a rising edge): state to IDLE, o_tx=1, o_busy=0, all counters cleared. o_fifo_inc=0 whenever i_rstn=0.
- Reset mid-frame: same as above at the next edge. The partially sent byte is lost and is not re-read.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_tx=1, o_busy=0.
  - o_fifo_inc = i_rstn & (state==IDLE) & ~i_fifo_empty, combinational.
  - On that edge: latch i_fifo_data into the shift register. Latch i_par_en, i_par_typ and P = max(i_prescale,1). Compute the parity bit. Go to START, and register o_tx <= 0.
  - o_fifo_inc is therefore high for exactly one cycle per word.
- Mid-frame configuration: config inputs are sampled only at the load edge. Changes during a frame have no effect until the next frame.
- Bit timing: each serial bit holds o_tx for exactly P cycles. A cycle counter runs 0..P-1 and wraps, and the state or bit advances on the wrap.
- START: o_tx=0 for P cycles, then go to DATA.
- DATA: D_SIZE bits, LSB first, with a bit index counter of clog2(D_SIZE) bits.
  - After the last bit, go to PARITY if the latched par_en=1, else go to STOP.
- PARITY: o_tx = ^data (even) or ~^data (odd) for P cycles, then go to STOP.
- STOP: o_tx=1 for P cycles, then go to IDLE.
- Frame length, load edge to return to IDLE: (D_SIZE+2+par_en)*P cycles.
- o_busy: high from the cycle after the load edge until IDLE is re-entered.
- Back-to-back frames: IDLE lasts at least one cycle, during which the pop of the next word may occur. The line therefore stays high P+1 cycles between consecutive frames.
- FIFO empty flag latency: the FIFO empty flag updates at least one cycle after inc. The block does not sample i_fifo_empty again until the frame completes, which is at least 10 cycles later. No double pop is possible.
- Underflow: no pop occurs while i_fifo_empty=1. The block waits in IDLE indefinitely with o_tx=1.
- o_tx is always driven from a flop: glitch-free.

Test Plan:
- Reset: i_rstn=0 with i_fifo_empty=0 for 3 cycles -> o_tx=1, o_busy=0, o_fifo_inc=0 throughout. Release -> o_fifo_inc pulses in the first cycle.
- Single word 0xA5, prescale=4, par_en=0:
  - o_fifo_inc high exactly 1 cycle.
  - o_tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then 1 for 4 cycles.
  - o_busy high for 40 cycles.
- Parity, prescale=2:
  - 0xA5 even -> parity bit 0.
  - 0xA5 odd -> 1.
  - 0x07 even -> 1.
  - Frame is 22 cycles.
- Back-to-back: FIFO holds 0x55, 0x00, 0xFF; prescale=1, par_en=0.
  - Exactly 3 o_fifo_inc pulses, 11 cycles apart.
  - Serial stream decodes to 0x55, 0x00, 0xFF.
  - No 4th pop after empty goes high.
- Prescale edge cases:
  - i_prescale=0 -> 1 cycle per bit.
  - i_prescale changed from 4 to 8 during data bit 2 -> current frame stays 4 cycles/bit; next frame uses 8.
- Reset mid-frame: i_rstn=0 for 1 cycle during data bit 3 -> next edge o_tx=1, o_busy=0. After release with FIFO non-empty -> new frame carries the next FIFO word, not the interrupted one.

Source files
------------

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes from a show-ahead FIFO read port and sends
// start, D_SIZE data bits LSB first, optional parity and one stop bit.
module uart_tx_fifo_reader #(
  parameter int D_SIZE  = 8,
  parameter int PRESC_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_fifo_empty,
  input  logic [D_SIZE-1:0]  i_fifo_data,
  output logic               o_fifo_inc,
  input  logic               i_par_en,
  input  logic               i_par_typ,
  input  logic [PRESC_W-1:0] i_prescale,
  output logic               o_tx,
  output logic               o_busy
);

  localparam int IDX_W = (D_SIZE > 1) ? $clog2(D_SIZE) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(D_SIZE - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ZERO = IDX_W'(0);
  localparam logic [PRESC_W-1:0] P_ONE    = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] P_ZERO   = PRESC_W'(0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit appended to the frame: even when odd_sel=0, odd when odd_sel=1.
  function automatic logic calc_parity(input logic [D_SIZE-1:0] data, input logic odd_sel);
    return (^data) ^ odd_sel;
  endfunction

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [D_SIZE-1:0]  shift_q, shift_d;
  logic               par_en_q, par_en_d;
  logic               par_bit_q, par_bit_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               load_s;
  logic               wrap_s;
  logic [D_SIZE-1:0]  shifted_s;

  assign load_s     = i_rstn & (state_q == S_IDLE) & ~i_fifo_empty;
  assign o_fifo_inc = load_s;
  assign wrap_s     = (cnt_q == (presc_q - P_ONE));
  assign shifted_s  = shift_q >> 1;
  assign o_tx       = tx_q;
  assign o_busy     = busy_q;

  // Next-state logic; o_tx is computed one cycle ahead so it leaves a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;

    if (state_q != S_IDLE) begin
      cnt_d = wrap_s ? P_ZERO : (cnt_q + P_ONE);
    end else begin
      cnt_d = P_ZERO;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (load_s) begin
          shift_d   = i_fifo_data;
          par_en_d  = i_par_en;
          par_bit_d = calc_parity(i_fifo_data, i_par_typ);
          presc_d   = (i_prescale == P_ZERO) ? P_ONE : i_prescale;
          bit_idx_d = IDX_ZERO;
          state_d   = S_START;
          tx_d      = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (wrap_s) begin
          state_d   = S_DATA;
          bit_idx_d = IDX_ZERO;
          tx_d      = shift_q[0];
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (wrap_s) begin
          if (bit_idx_q == LAST_IDX) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_ONE;
            shift_d   = shifted_s;
            tx_d      = shifted_s[0];
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (wrap_s) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (wrap_s) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= P_ZERO;
      presc_q   <= P_ONE;
      bit_idx_q <= IDX_ZERO;
      shift_q   <= {D_SIZE{1'b0}};
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed self-checking bench for uart_tx_fifo_reader with a small
// show-ahead FIFO model feeding the read port.
module tb_uart_tx_fifo_reader;

  logic       clk;
  logic       rstn;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_inc;
  logic       par_en;
  logic       par_typ;
  logic [7:0] prescale;
  logic       tx;
  logic       busy;

  logic [7:0] fifo_mem [0:31];
  logic [4:0] wr_ptr;
  logic [4:0] rd_ptr = 5'd0;

  logic tx_log   [0:255];
  logic busy_log [0:255];
  logic inc_log  [0:255];

  int total;
  int bad;

  uart_tx_fifo_reader #(.D_SIZE(8), .PRESC_W(8)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_fifo_empty(fifo_empty),
    .i_fifo_data (fifo_data),
    .o_fifo_inc  (fifo_inc),
    .i_par_en    (par_en),
    .i_par_typ   (par_typ),
    .i_prescale  (prescale),
    .o_tx        (tx),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fifo_mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_inc) rd_ptr <= rd_ptr + 5'd1;
  end

  // Expected line level k cycles after the pop cycle (k=0) of one frame.
  function automatic logic exp_tx(input int k, input logic [7:0] d, input int p,
                                  input logic pe, input logic pb);
    int b;
    if (k <= 0) return 1'b1;
    b = (k - 1) / p;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pe && b == 9) return pb;
    return 1'b1;
  endfunction

  function automatic int count_busy(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (busy_log[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_inc(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (inc_log[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  // Called at a negedge; logs n cycles, optionally changing prescale at cycle chg_at.
  task automatic run_cycles(input int n, input int chg_at, input logic [7:0] chg_val);
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) prescale = chg_val;
      #1;
      tx_log[i]   = tx;
      busy_log[i] = busy;
      inc_log[i]  = fifo_inc;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    prescale = 8'd1;
    push(8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++;
      if ({tx, busy, fifo_inc} !== 3'b100) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d tx/busy/inc got=%b%b%b want=100", i, tx, busy, fifo_inc);
      end
    end
    rstn = 1'b1;
    #1;
    total++;
    if (fifo_inc !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_inc got=%b want=1", fifo_inc);
    end
    run_cycles(12, -1, 8'd0);
    total++;
    if (count_busy(12) != 10) begin
      bad++;
      $display("FAIL reset_frame_busy got=%0d want=10", count_busy(12));
    end
    for (int k = 0; k < 12; k++) begin
      total++;
      if (tx_log[k] !== exp_tx(k, 8'h3C, 1, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL reset_frame_tx k=%0d got=%b want=%b", k, tx_log[k], exp_tx(k, 8'h3C, 1, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_single;
    prescale = 8'd4;
    par_en = 1'b0;
    push(8'hA5);
    run_cycles(45, -1, 8'd0);
    total++;
    if (count_inc(45) != 1 || inc_log[0] !== 1'b1) begin
      bad++;
      $display("FAIL single_inc count=%0d first=%b want=1/1", count_inc(45), inc_log[0]);
    end
    total++;
    if (count_busy(45) != 40) begin
      bad++;
      $display("FAIL single_busy got=%0d want=40", count_busy(45));
    end
    for (int k = 0; k < 45; k++) begin
      total++;
      if (tx_log[k] !== exp_tx(k, 8'hA5, 4, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL single_tx k=%0d got=%b want=%b", k, tx_log[k], exp_tx(k, 8'hA5, 4, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_parity;
    logic [7:0] dv [0:2];
    logic       tv [0:2];
    logic       pv [0:2];
    dv[0] = 8'hA5; tv[0] = 1'b0; pv[0] = 1'b0;
    dv[1] = 8'hA5; tv[1] = 1'b1; pv[1] = 1'b1;
    dv[2] = 8'h07; tv[2] = 1'b0; pv[2] = 1'b1;
    prescale = 8'd2;
    par_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      par_typ = tv[c];
      push(dv[c]);
      run_cycles(25, -1, 8'd0);
      total++;
      if (count_busy(25) != 22) begin
        bad++;
        $display("FAIL parity_busy case=%0d got=%0d want=22", c, count_busy(25));
      end
      total++;
      if (tx_log[19] !== pv[c] || tx_log[20] !== pv[c]) begin
        bad++;
        $display("FAIL parity_bit case=%0d got=%b%b want=%b", c, tx_log[19], tx_log[20], pv[c]);
      end
      for (int k = 0; k < 25; k++) begin
        total++;
        if (tx_log[k] !== exp_tx(k, dv[c], 2, 1'b1, pv[c])) begin
          bad++;
          $display("FAIL parity_tx case=%0d k=%0d got=%b want=%b", c, k, tx_log[k], exp_tx(k, dv[c], 2, 1'b1, pv[c]));
        end
      end
    end
    par_en = 1'b0;
    par_typ = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] ev [0:2];
    logic [7:0] got;
    ev[0] = 8'h55; ev[1] = 8'h00; ev[2] = 8'hFF;
    prescale = 8'd1;
    push(ev[0]); push(ev[1]); push(ev[2]);
    run_cycles(40, -1, 8'd0);
    total++;
    if (count_inc(40) != 3) begin
      bad++;
      $display("FAIL b2b_pop_count got=%0d want=3", count_inc(40));
    end
    for (int f = 0; f < 3; f++) begin
      total++;
      if (inc_log[11*f] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_pop_pos frame=%0d got=%b want=1", f, inc_log[11*f]);
      end
      total++;
      if (tx_log[11*f+1] !== 1'b0 || tx_log[11*f+10] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_framing frame=%0d start=%b stop=%b want=0/1", f, tx_log[11*f+1], tx_log[11*f+10]);
      end
      for (int j = 0; j < 8; j++) got[j] = tx_log[11*f+2+j];
      total++;
      if (got !== ev[f]) begin
        bad++;
        $display("FAIL b2b_decode frame=%0d got=%h want=%h", f, got, ev[f]);
      end
    end
    total++;
    if (rd_ptr !== wr_ptr) begin
      bad++;
      $display("FAIL b2b_fifo_ptr rd=%0d want=%0d", rd_ptr, wr_ptr);
    end
  endtask

  task automatic test_prescale_zero;
    prescale = 8'd0;
    push(8'h96);
    run_cycles(13, -1, 8'd0);
    total++;
    if (count_busy(13) != 10) begin
      bad++;
      $display("FAIL presc0_busy got=%0d want=10", count_busy(13));
    end
    for (int k = 0; k < 13; k++) begin
      total++;
      if (tx_log[k] !== exp_tx(k, 8'h96, 1, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL presc0_tx k=%0d got=%b want=%b", k, tx_log[k], exp_tx(k, 8'h96, 1, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_prescale_change;
    prescale = 8'd4;
    push(8'h5A);
    push(8'hC3);
    run_cycles(125, 14, 8'd8);
    total++;
    if (count_inc(125) != 2 || inc_log[41] !== 1'b1) begin
      bad++;
      $display("FAIL pchg_pops count=%0d at41=%b want=2/1", count_inc(125), inc_log[41]);
    end
    total++;
    if (count_busy(125) != 120) begin
      bad++;
      $display("FAIL pchg_busy got=%0d want=120", count_busy(125));
    end
    for (int k = 0; k < 41; k++) begin
      total++;
      if (tx_log[k] !== exp_tx(k, 8'h5A, 4, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL pchg_tx1 k=%0d got=%b want=%b", k, tx_log[k], exp_tx(k, 8'h5A, 4, 1'b0, 1'b0));
      end
    end
    for (int k = 41; k < 125; k++) begin
      total++;
      if (tx_log[k] !== exp_tx(k - 41, 8'hC3, 8, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL pchg_tx2 k=%0d got=%b want=%b", k, tx_log[k], exp_tx(k - 41, 8'hC3, 8, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_reset_mid;
    prescale = 8'd2;
    push(8'h11);
    push(8'h82);
    run_cycles(10, -1, 8'd0);
    total++;
    if (tx_log[9] !== 1'b0 || busy_log[9] !== 1'b1) begin
      bad++;
      $display("FAIL rmid_bit3 tx=%b busy=%b want=0/1", tx_log[9], busy_log[9]);
    end
    rstn = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({tx, busy, fifo_inc} !== 3'b100) begin
      bad++;
      $display("FAIL rmid_after_reset tx/busy/inc got=%b%b%b want=100", tx, busy, fifo_inc);
    end
    rstn = 1'b1;
    run_cycles(23, -1, 8'd0);
    total++;
    if (count_inc(23) != 1 || inc_log[0] !== 1'b1) begin
      bad++;
      $display("FAIL rmid_pop count=%0d first=%b want=1/1", count_inc(23), inc_log[0]);
    end
    for (int k = 0; k < 23; k++) begin
      total++;
      if (tx_log[k] !== exp_tx(k, 8'h82, 2, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL rmid_tx k=%0d got=%b want=%b", k, tx_log[k], exp_tx(k, 8'h82, 2, 1'b0, 1'b0));
      end
    end
    total++;
    if (rd_ptr !== wr_ptr) begin
      bad++;
      $display("FAIL rmid_fifo_ptr rd=%0d want=%0d", rd_ptr, wr_ptr);
    end
  endtask

  initial begin
    rstn = 1'b0;
    par_en = 1'b0;
    par_typ = 1'b0;
    prescale = 8'd1;
    wr_ptr = 5'd0;
    total = 0;
    bad = 0;
    test_reset;
    test_single;
    test_parity;
    test_back_to_back;
    test_prescale_zero;
    test_prescale_change;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
